// File: rtl/sdft_pkg.sv
// Shared types and default sizing for the sliding-DFT sequencer and its
// interface.
package sdft_pkg;

    localparam int DEFAULT_FREQ_BINS = 16;
    localparam int DEFAULT_PIPE_LAT  = 2;

    typedef enum logic [1:0] {
        IDLE,
        DELTA,
        SWEEP,
        DRAIN
    } sdft_state_e;

    // Width of a counter holding 0..n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sdft_sequencer_if.sv
// Sample-intake, bin-RAM and readout signals between the sequencer (master)
// and the datapath/host side (slave).
interface sdft_sequencer_if
    import sdft_pkg::*;
#(
    parameter int FREQ_BINS = DEFAULT_FREQ_BINS
);
    localparam int AW = $clog2(FREQ_BINS);

    logic          sample_valid;
    logic          sample_ready;
    logic          sample_wr_en;
    logic [AW-1:0] sample_ptr;
    logic          delta_en;
    logic          bin_rd_en;
    logic [AW-1:0] bin_addr;
    logic [AW-1:0] tw_addr;
    logic          bin_wr_en;
    logic [AW-1:0] wr_addr;
    logic          rd_req;
    logic [AW-1:0] rd_addr_in;
    logic          rd_gnt;
    logic          busy;
    logic          overrun;

    modport master (
        input  sample_valid, rd_req, rd_addr_in,
        output sample_ready, sample_wr_en, sample_ptr, delta_en,
               bin_rd_en, bin_addr, tw_addr, bin_wr_en, wr_addr,
               rd_gnt, busy, overrun
    );

    modport slave (
        output sample_valid, rd_req, rd_addr_in,
        input  sample_ready, sample_wr_en, sample_ptr, delta_en,
               bin_rd_en, bin_addr, tw_addr, bin_wr_en, wr_addr,
               rd_gnt, busy, overrun
    );

endinterface

// File: rtl/sdft_delay_line.sv
// Fixed-depth shift register that carries a word DEPTH cycles downstream;
// reset clears every stage.
module sdft_delay_line #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] stage [DEPTH];

    // NOTE: every stage is reset, unlike a RAM array; a stale valid bit
    // left in flight would fire a write-back after reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage[i] <= '0;
            end
        end else begin
            stage[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign dout = stage[DEPTH-1];

endmodule

// File: rtl/sdft_sequencer.sv
// Sliding-DFT control sequencer: per accepted sample, one delta cycle, a sweep
// over all bins, and a drain while the last write-backs retire.
module sdft_sequencer
    import sdft_pkg::*;
#(
    parameter int FREQ_BINS = DEFAULT_FREQ_BINS,
    parameter int PIPE_LAT  = DEFAULT_PIPE_LAT
) (
    input  logic             clk,
    input  logic             reset,
    sdft_sequencer_if.master bus
);

    localparam int            AW         = $clog2(FREQ_BINS);
    localparam int            DW         = cnt_width(PIPE_LAT);
    localparam logic [AW-1:0] LAST_BIN   = AW'(FREQ_BINS - 1);
    localparam logic [DW-1:0] LAST_DRAIN = DW'(PIPE_LAT - 1);

    sdft_state_e   state;
    sdft_state_e   state_nxt;
    logic [AW-1:0] sweep_idx;
    logic [DW-1:0] drain_cnt;
    logic [AW-1:0] sample_ptr;
    logic          overrun;

    logic          accept;
    logic          drop;
    logic          sample_ready;
    logic          sample_wr_en;
    logic          delta_en;
    logic          bin_rd_en;
    logic [AW-1:0] bin_addr;
    logic [AW-1:0] tw_addr;
    logic          rd_gnt;
    logic          busy;
    logic [AW:0]   wb_in;
    logic [AW:0]   wb_out;

    assign accept = bus.sample_valid && (state == IDLE);
    assign drop   = bus.sample_valid && (state != IDLE);

    // NOTE: sequential state uses <= so every register samples the
    // pre-edge values; blocking here would make ordering matter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            sweep_idx  <= '0;
            drain_cnt  <= '0;
            sample_ptr <= '0;
            overrun    <= 1'b0;
        end else begin
            state     <= state_nxt;
            sweep_idx <= (state == SWEEP) ? sweep_idx + AW'(1) : '0;
            drain_cnt <= (state == DRAIN) ? drain_cnt + DW'(1) : '0;
            if (state == DRAIN && state_nxt == IDLE) begin
                sample_ptr <= sample_ptr + AW'(1);
            end
            if (drop) begin
                overrun <= 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:  if (accept) state_nxt = DELTA;
            DELTA: state_nxt = SWEEP;
            SWEEP: if (sweep_idx == LAST_BIN) state_nxt = DRAIN;
            DRAIN: if (drain_cnt == LAST_DRAIN) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: every output gets a default before the case so no path
    // leaves one unassigned and infers a latch.
    always_comb begin
        sample_ready = 1'b0;
        sample_wr_en = 1'b0;
        delta_en     = 1'b0;
        bin_rd_en    = 1'b0;
        bin_addr     = '0;
        tw_addr      = '0;
        rd_gnt       = 1'b0;
        busy         = 1'b1;
        unique case (state)
            IDLE: begin
                sample_ready = 1'b1;
                busy         = 1'b0;
                if (bus.sample_valid) begin
                    sample_wr_en = 1'b1;
                    delta_en     = 1'b1;
                end else if (bus.rd_req) begin
                    rd_gnt    = 1'b1;
                    bin_rd_en = 1'b1;
                    bin_addr  = bus.rd_addr_in;
                end
            end
            SWEEP: begin
                bin_rd_en = 1'b1;
                bin_addr  = sweep_idx;
                tw_addr   = sweep_idx;
            end
            default: ;
        endcase
    end

    // Only sweep reads produce write-backs; readout grants never enter the line.
    assign wb_in = {state == SWEEP, tw_addr};

    sdft_delay_line #(
        .WIDTH(AW + 1),
        .DEPTH(PIPE_LAT)
    ) u_wb_delay (
        .clk  (clk),
        .reset(reset),
        .din  (wb_in),
        .dout (wb_out)
    );

    assign bus.sample_ready = sample_ready;
    assign bus.sample_wr_en = sample_wr_en;
    assign bus.sample_ptr   = sample_ptr;
    assign bus.delta_en     = delta_en;
    assign bus.bin_rd_en    = bin_rd_en;
    assign bus.bin_addr     = bin_addr;
    assign bus.tw_addr      = tw_addr;
    assign bus.bin_wr_en    = wb_out[AW];
    assign bus.wr_addr      = wb_out[AW-1:0];
    assign bus.rd_gnt       = rd_gnt;
    assign bus.busy         = busy;
    assign bus.overrun      = overrun;

endmodule

// File: tb/tb_sdft_sequencer.sv
// Self-checking bench for sdft_sequencer: directed scenarios plus random
// traffic compared every cycle against a cycle-offset reference model.
module tb_sdft_sequencer;

    localparam int N  = 16;
    localparam int P  = 2;
    localparam int AW = $clog2(N);

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    sdft_sequencer_if #(.FREQ_BINS(N)) bus ();

    sdft_sequencer #(
        .FREQ_BINS(N),
        .PIPE_LAT (P)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    task automatic check(input string name, input logic [31:0] actual,
                         input logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // Reference model: the only state is whether a sample is in flight, the
    // cycle it was accepted, the ring pointer and the sticky overrun flag.
    // Every output follows from the offset of the current cycle from acceptance.
    bit m_on  = 0;
    bit m_act = 0;
    int m_ta  = 0;
    int m_ptr = 0;
    bit m_ovr = 0;

    int ph;
    bit e_ready, e_busy, e_wr, e_delta, e_rd, e_bwr, e_gnt;
    int e_addr, e_tw, e_waddr;

    always @(negedge clk) begin
        if (reset) begin
            m_on  = 1;
            m_act = 0;
            m_ptr = 0;
            m_ovr = 0;
        end else if (m_on) begin
            if (!m_act) begin
                e_ready = 1; e_busy = 0;
                e_wr    = bus.sample_valid;
                e_delta = bus.sample_valid;
                e_gnt   = bus.rd_req && !bus.sample_valid;
                e_rd    = e_gnt;
                e_addr  = e_gnt ? int'(bus.rd_addr_in) : 0;
                e_tw    = 0;
                e_bwr   = 0;
                e_waddr = 0;
            end else begin
                ph      = cyc - m_ta;
                e_ready = 0; e_busy = 1;
                e_wr    = 0; e_delta = 0; e_gnt = 0;
                e_rd    = (ph >= 2) && (ph <= 1 + N);
                e_addr  = e_rd ? ph - 2 : 0;
                e_tw    = e_addr;
                e_bwr   = (ph >= 2 + P) && (ph <= 1 + N + P);
                e_waddr = e_bwr ? ph - 2 - P : 0;
            end
            check("sample_ready", bus.sample_ready, e_ready);
            check("busy",         bus.busy,         e_busy);
            check("sample_wr_en", bus.sample_wr_en, e_wr);
            check("delta_en",     bus.delta_en,     e_delta);
            check("bin_rd_en",    bus.bin_rd_en,    e_rd);
            check("bin_addr",     bus.bin_addr,     e_addr);
            check("tw_addr",      bus.tw_addr,      e_tw);
            check("bin_wr_en",    bus.bin_wr_en,    e_bwr);
            check("wr_addr",      bus.wr_addr,      e_waddr);
            check("rd_gnt",       bus.rd_gnt,       e_gnt);
            check("sample_ptr",   bus.sample_ptr,   m_ptr);
            check("overrun",      bus.overrun,      m_ovr);

            if (!m_act) begin
                if (bus.sample_valid) begin
                    m_act = 1;
                    m_ta  = cyc;
                end
            end else begin
                if (bus.sample_valid) m_ovr = 1;
                if (cyc - m_ta == 1 + N + P) begin
                    m_act = 0;
                    m_ptr = (m_ptr + 1) % N;
                end
            end
        end
        cyc++;
    end

    // A write-back must trace to a sweep read exactly P cycles earlier, same address.
    property p_wr_window;
        @(posedge clk) disable iff (reset)
        bus.bin_wr_en |-> ($past(bus.bin_rd_en && bus.busy, P) &&
                           bus.wr_addr == $past(bus.bin_addr, P));
    endproperty

    a_wr_window: assert property (p_wr_window)
        else begin
            fails++;
            $display("FAIL wr_window: bin_wr_en at wr_addr %0d without a matching sweep read", bus.wr_addr);
        end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.sample_valid = 1'b0;
        bus.rd_req       = 1'b0;
        bus.rd_addr_in   = '0;
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        repeat (n) tick();
        reset = 1'b0;
    endtask

    task automatic wait_ready(input string name);
        int budget = 0;
        while (!bus.sample_ready && budget < 100) begin
            tick();
            budget++;
        end
        check(name, budget < 100, 1);
    endtask

    task automatic test_single();
        int first_rd = -1, last_rd = -1, nrd = 0;
        int first_wr = -1, last_wr = -1, nwr = 0;
        int ready_at = -1, ptr_at = -1;
        bus.sample_valid = 1'b1;
        for (int k = 0; k < 24; k++) begin
            @(negedge clk);
            if (bus.bin_rd_en) begin
                if (first_rd < 0) first_rd = k;
                last_rd = k;
                nrd++;
            end
            if (bus.bin_wr_en) begin
                if (first_wr < 0) first_wr = k;
                last_wr = k;
                nwr++;
            end
            if (k > 0 && bus.sample_ready && ready_at < 0) begin
                ready_at = k;
                ptr_at   = int'(bus.sample_ptr);
            end
            tick();
            bus.sample_valid = 1'b0;
        end
        check("single_first_read",  first_rd, 2);
        check("single_last_read",   last_rd,  17);
        check("single_read_count",  nrd,      16);
        check("single_first_write", first_wr, 4);
        check("single_last_write",  last_wr,  19);
        check("single_write_count", nwr,      16);
        check("single_ready_cycle", ready_at, 20);
        check("single_ptr_after",   ptr_at,   1);
    endtask

    task automatic test_back_to_back();
        do_reset(2);
        for (int s = 0; s < N; s++) begin
            wait_ready("b2b_ready_timeout");
            if (s == N - 1) check("b2b_ptr_before_wrap", bus.sample_ptr, N - 1);
            bus.sample_valid = 1'b1;
            tick();
            bus.sample_valid = 1'b0;
        end
        wait_ready("b2b_final_timeout");
        check("b2b_ptr_wrapped", bus.sample_ptr, 0);
        check("b2b_overrun",     bus.overrun,    0);
    endtask

    task automatic test_overrun();
        int k = 6;
        wait_ready("ovr_ready_timeout");
        bus.sample_valid = 1'b1;
        tick();
        bus.sample_valid = 1'b0;
        repeat (4) tick();
        bus.sample_valid = 1'b1;
        @(negedge clk);
        check("ovr_no_strobe",  bus.sample_wr_en, 0);
        check("ovr_sweep_addr", bus.bin_addr,     3);
        tick();
        bus.sample_valid = 1'b0;
        @(negedge clk);
        check("ovr_set", bus.overrun, 1);
        while (!bus.sample_ready && k < 100) begin
            tick();
            k++;
        end
        check("ovr_sweep_end_cycle", k,              20);
        check("ovr_held",            bus.overrun,    1);
        check("ovr_ptr",             bus.sample_ptr, 1);
    endtask

    task automatic test_readout();
        int gnt_at = -1, gnt_addr = -1;
        bus.rd_req     = 1'b1;
        bus.rd_addr_in = AW'(7);
        @(negedge clk);
        check("rd_gnt_idle",  bus.rd_gnt,    1);
        check("rd_addr_idle", bus.bin_addr,  7);
        check("rd_en_idle",   bus.bin_rd_en, 1);
        tick();
        bus.rd_addr_in   = AW'(3);
        bus.sample_valid = 1'b1;
        @(negedge clk);
        check("rd_collide_gnt",    bus.rd_gnt,       0);
        check("rd_collide_accept", bus.sample_wr_en, 1);
        tick();
        bus.sample_valid = 1'b0;
        for (int k = 1; k < 30; k++) begin
            @(negedge clk);
            if (bus.rd_gnt && gnt_at < 0) begin
                gnt_at   = k;
                gnt_addr = int'(bus.bin_addr);
            end
            tick();
        end
        check("rd_deferred_cycle", gnt_at,   20);
        check("rd_deferred_addr",  gnt_addr, 3);
        idle_inputs();
    endtask

    task automatic test_reset_mid();
        int late_wr = 0;
        wait_ready("rst_ready_timeout");
        bus.sample_valid = 1'b1;
        tick();
        bus.sample_valid = 1'b0;
        repeat (10) tick();
        reset = 1'b1;
        @(negedge clk);
        check("rst_at_index9", bus.bin_addr, 9);
        tick();
        reset = 1'b0;
        @(negedge clk);
        check("rst_busy",      bus.busy,         0);
        check("rst_ready",     bus.sample_ready, 1);
        check("rst_ptr",       bus.sample_ptr,   0);
        check("rst_overrun",   bus.overrun,      0);
        check("rst_bin_rd_en", bus.bin_rd_en,    0);
        check("rst_bin_addr",  bus.bin_addr,     0);
        check("rst_tw_addr",   bus.tw_addr,      0);
        check("rst_wr_addr",   bus.wr_addr,      0);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (bus.bin_wr_en) late_wr++;
        end
        check("rst_no_late_write", late_wr, 0);
        tick();
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            bus.sample_valid = ($urandom_range(0, 99) < 8);
            bus.rd_req       = ($urandom_range(0, 3) == 0);
            bus.rd_addr_in   = AW'($urandom_range(0, N - 1));
            reset            = ($urandom_range(0, 999) == 0);
            tick();
        end
        reset = 1'b0;
        idle_inputs();
        repeat (30) tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        idle_inputs();
        do_reset(3);
        @(negedge clk);
        check("init_busy",    bus.busy,         0);
        check("init_ready",   bus.sample_ready, 1);
        check("init_ptr",     bus.sample_ptr,   0);
        check("init_overrun", bus.overrun,      0);
        check("init_wr_en",   bus.bin_wr_en,    0);
        tick();

        test_single();
        test_back_to_back();
        test_overrun();
        test_readout();
        test_reset_mid();
        test_random();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
